imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_if.sv | 39 +++
 rtl/imem_loader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader: the FSM state
// encoding and the framing constants of the incoming byte stream.
// ---------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  // Header is a 16-bit little-endian word count.
  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
// Groups the loader's control, byte-stream and memory-write signals.
//   load_req  : single-cycle pulse starting a program load
//   in_valid  : source has a byte on in_data
//   in_data   : stream byte
//   in_ready  : loader accepts a byte (transfer on in_valid && in_ready)
//   wr_en     : one-cycle instruction-memory write strobe
//   wr_addr   : word-aligned byte address of the write
//   wr_data   : instruction word to write
//   cpu_hold  : holds the processor in reset while high
//   done      : last load completed successfully
//   err       : last load was rejected
// slave  = loader side, master = source / memory / system side.
// ---------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int ADDR_W = 12
);
  logic              load_req;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              done;
  logic              err;

  modport slave (
    input  load_req, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
  );

  modport master (
    output load_req, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Receives a program as a byte stream (2-byte little-endian word count,
// then little-endian 32-bit words) and writes it into instruction memory
// starting at address 0, holding the processor in reset until the load
// completes.
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : imem_loader_if.slave (stream in, memory write out, status)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset, waiting for load_req, cpu held
// LEN    | accepting the 2 header bytes (word count N)
// DATA   | accepting N words, one write strobe per assembled word
// DONE   | load good, cpu released, waiting for a new load_req
// ERR    | header rejected (N==0 or N>MEM_WORDS), cpu held
// ---------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = 12
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);

  // Must reach MEM_WORDS itself without wrapping.
  localparam int WCNT_W = $clog2(MEM_WORDS + 1);

  state_t            r_state;
  logic [1:0]        r_byte_cnt;
  logic [WCNT_W-1:0] r_word_cnt;
  logic [15:0]       r_len;
  logic [23:0]       r_shift;     // first three bytes of the word in flight
  logic              r_in_ready;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_err;

  logic              w_accept;
  logic [31:0]       w_word;
  logic [15:0]       w_len;
  logic              w_len_bad;
  logic              w_last_word;

  assign w_accept    = bus.in_valid && r_in_ready;
  // Current byte completes the word / header combinationally so the write
  // can be registered on the accepting edge (one-cycle latency).
  assign w_word      = {bus.in_data, r_shift};
  assign w_len       = {bus.in_data, r_len[7:0]};
  assign w_len_bad   = (w_len == 16'd0) || (32'(w_len) > 32'(MEM_WORDS));
  assign w_last_word = ((32'(r_word_cnt) + 32'd1) == 32'(r_len));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= '0;
      r_word_cnt <= '0;
      r_len      <= '0;
      r_shift    <= '0;
      r_in_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.load_req) begin
            r_state    <= S_LEN;
            r_in_ready <= 1'b1;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_len      <= '0;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
          end
        end

        S_LEN: begin
          if (w_accept) begin
            if (r_byte_cnt == 2'(LEN_BYTES - 1)) begin
              r_byte_cnt <= '0;
              r_len      <= w_len;
              if (w_len_bad) begin
                r_state    <= S_ERR;
                r_in_ready <= 1'b0;
                r_err      <= 1'b1;
              end else begin
                r_state <= S_DATA;
              end
            end else begin
              r_len[7:0] <= bus.in_data;
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end
        end

        S_DATA: begin
          if (w_accept) begin
            r_shift <= {bus.in_data, r_shift[23:8]};
            if (r_byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
              r_byte_cnt <= '0;
              r_wr_en    <= 1'b1;
              r_wr_addr  <= ADDR_W'({r_word_cnt, 2'b00});
              r_wr_data  <= w_word;
              r_word_cnt <= r_word_cnt + WCNT_W'(1);
              // Final strobe lands in the first DONE cycle.
              if (w_last_word) begin
                r_state    <= S_DONE;
                r_in_ready <= 1'b0;
                r_done     <= 1'b1;
                r_cpu_hold <= 1'b0;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_cpu_hold <= 1'b1;
          r_done     <= 1'b0;
          r_err      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.cpu_hold = r_cpu_hold;
  assign bus.done     = r_done;
  assign bus.err      = r_err;

endmodule
